pattern_tx_1101: RTL and testbench



---
 rtl/pattern_tx_pkg.sv | 19 +
 rtl/pattern_shift_reg.sv | 35 +++
 rtl/pattern_tx_1101.sv | 173 +++++++++++++++++
 tb/tb_pattern_tx_1101.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern_tx serial pattern transmitter:
// FSM state encoding, default pattern and the pattern-width type.
package pattern_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3,
        PAR   = 3'd4
    } state_t;

    localparam int PAT_W_DEFAULT = 4;

    typedef logic [PAT_W_DEFAULT-1:0] pattern_t;

    localparam pattern_t PAT_DEFAULT_VALUE = 4'b1101;

endpackage

// File: rtl/pattern_shift_reg.sv
// MSB-first shift register with parallel load; exposes the current MSB and
// the bit that becomes MSB after the next shift.
module pattern_shift_reg
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_VALUE)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_value,
    output logic             msb,
    output logic             next_msb
);

    logic [PAT_W-1:0] sr;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sr <= PAT_DEFAULT;
        end else if (load) begin
            sr <= load_value;
        end else if (shift) begin
            sr <= {sr[PAT_W-2:0], 1'b0};
        end
    end

    assign msb      = sr[PAT_W-1];
    assign next_msb = sr[PAT_W-2];

endmodule

// File: rtl/pattern_tx_1101.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated
// with idle gaps. Define PATTERN_TX_PARITY_EN to append an even-parity bit.
module pattern_tx_1101
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_VALUE),
    parameter int               CNT_W       = 4,
    parameter int               GAP_W       = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             ready,
    output logic             dout,
    output logic             valid,
    output logic             done
);

    localparam int               BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] ONE_BIT  = BIT_W'(1);
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);
    localparam logic [GAP_W-1:0] ONE_GAP  = GAP_W'(1);

    state_t           state, state_n;
    logic [PAT_W-1:0] cap_pat, cap_pat_n;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
    logic [GAP_W-1:0] gap_len, gap_len_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;

    logic             sr_load, sr_shift, sr_msb, sr_next_msb;
    logic [PAT_W-1:0] sr_load_value;
    logic             rep_end;
    logic             msb_n, dout_n, valid_n;

    pattern_shift_reg #(
        .PAT_W       (PAT_W),
        .PAT_DEFAULT (PAT_DEFAULT)
    ) u_shift_reg (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (sr_load),
        .shift      (sr_shift),
        .load_value (sr_load_value),
        .msb        (sr_msb),
        .next_msb   (sr_next_msb)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_n       = state;
        cap_pat_n     = cap_pat;
        rep_cnt_n     = rep_cnt;
        gap_len_n     = gap_len;
        gap_cnt_n     = gap_cnt;
        bit_cnt_n     = bit_cnt;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        sr_load_value = cap_pat;
        rep_end       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    cap_pat_n     = pattern;
                    rep_cnt_n     = (reps == '0) ? ONE_REP : reps;
                    gap_len_n     = gap;
                    bit_cnt_n     = '0;
                    sr_load       = 1'b1;
                    sr_load_value = pattern;
                    state_n       = SHIFT;
                end
            end
            SHIFT: begin
                sr_shift = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_n = '0;
`ifdef PATTERN_TX_PARITY_EN
                    state_n   = PAR;
`else
                    rep_end   = 1'b1;
`endif
                end else begin
                    bit_cnt_n = bit_cnt + ONE_BIT;
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            PAR: begin
                rep_end = 1'b1;
            end
`endif
            GAP: begin
                if (gap_cnt == ONE_GAP) begin
                    sr_load = 1'b1;
                    state_n = SHIFT;
                end else begin
                    gap_cnt_n = gap_cnt - ONE_GAP;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Shared end-of-repetition decision; a reload overrides the shift.
        if (rep_end) begin
            rep_cnt_n = rep_cnt - ONE_REP;
            if (rep_cnt == ONE_REP) begin
                state_n = DONE;
            end else if (gap_len == '0) begin
                sr_load = 1'b1;
                state_n = SHIFT;
            end else begin
                gap_cnt_n = gap_len;
                state_n   = GAP;
            end
        end
    end

    // Outputs are registered from the next-state view, so dout shows the bit
    // the shift register will hold after this edge.
    always_comb begin
        msb_n   = sr_load ? sr_load_value[PAT_W-1] : (sr_shift ? sr_next_msb : sr_msb);
        dout_n  = 1'b0;
        valid_n = 1'b0;
        if (state_n == SHIFT) begin
            dout_n  = msb_n;
            valid_n = 1'b1;
        end
`ifdef PATTERN_TX_PARITY_EN
        if (state_n == PAR) begin
            dout_n  = ^cap_pat;
            valid_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            cap_pat <= PAT_DEFAULT;
            rep_cnt <= '0;
            gap_len <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            dout    <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cap_pat <= cap_pat_n;
            rep_cnt <= rep_cnt_n;
            gap_len <= gap_len_n;
            gap_cnt <= gap_cnt_n;
            bit_cnt <= bit_cnt_n;
            ready   <= (state_n == IDLE);
            dout    <= dout_n;
            valid   <= valid_n;
            done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_pattern_tx_1101.sv
// Self-checking bench for pattern_tx_1101: frame-level reference model with
// per-cycle comparison, directed literal checks and randomized traffic.
module tb_pattern_tx_1101;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clk   = 1'b0;
    logic             clr_n = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] reps    = '0;
    logic [GAP_W-1:0] gap     = '0;
    logic             ready, dout, valid, done;

    pattern_tx_1101 #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .GAP_W (GAP_W)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .gap     (gap),
        .ready   (ready),
        .dout    (dout),
        .valid   (valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Observation per cycle: {dout, valid, done, ready}
    typedef struct packed {
        logic dout;
        logic valid;
        logic done;
        logic ready;
    } obs_t;

    localparam obs_t IDLE_OBS = 4'b0001;

    obs_t        exp_q[$];
    obs_t        cur_exp = IDLE_OBS;
    int          n_cmp   = 0;
    int          n_err   = 0;
    logic [63:0] log_dout, log_valid, log_done, log_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Whole frame as a list of cycles, built straight from the transfer rules.
    task automatic build_frame(input logic [PAT_W-1:0] p, input int r, input int g);
        int n;
        n = (r == 0) ? 1 : r;
        for (int i = 0; i < n; i++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b0, 1'b0});
`ifdef PATTERN_TX_PARITY_EN
            exp_q.push_back({^p, 1'b1, 1'b0, 1'b0});
`endif
            if (i < n - 1) begin
                for (int k = 0; k < g; k++) exp_q.push_back(4'b0000);
            end
        end
        exp_q.push_back(4'b0010);
    endtask

    task automatic clear_logs();
        log_dout  = '0;
        log_valid = '0;
        log_done  = '0;
        log_ready = '0;
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        if (!clr_n) begin
            exp_q.delete();
            cur_exp = IDLE_OBS;
        end else if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
        end else if (cur_exp.ready && start) begin
            build_frame(pattern, int'(reps), int'(gap));
            cur_exp = exp_q.pop_front();
        end else begin
            cur_exp = IDLE_OBS;
        end
        #1;
        check("cycle{dout,valid,done,ready}", {60'd0, dout, valid, done, ready}, {60'd0, cur_exp});
        log_dout  = {log_dout[62:0], dout};
        log_valid = {log_valid[62:0], valid};
        log_done  = {log_done[62:0], done};
        log_ready = {log_ready[62:0], ready};
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset();
        #2;
        clr_n = 1'b0;
        #1;
        exp_q.delete();
        cur_exp = IDLE_OBS;
        check("async_reset_outputs", {60'd0, dout, valid, done, ready}, 64'h1);
        step();
        step();
        clr_n = 1'b1;
    endtask

    task automatic launch(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                          input logic [GAP_W-1:0] g, input int n_steps);
        pattern = p;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        clear_logs();
        step();
        start = 1'b0;
        for (int i = 1; i < n_steps; i++) step();
    endtask

    task automatic drain();
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && cur_exp.ready) break;
            step();
        end
        step();
    endtask

    function automatic int count_1101(input logic [63:0] v, input int n);
        int c;
        c = 0;
        for (int i = 0; i + 3 < n; i++) begin
            if (v[i +: 4] == 4'b1101) c++;
        end
        return c;
    endfunction

    initial begin
        clear_logs();
        #2;
        clr_n = 1'b0;
        #1;
        check("reset_outputs", {60'd0, dout, valid, done, ready}, 64'h1);
        step();
        step();
        clr_n = 1'b1;
        step();
        step();

        // Single 1101 frame: bits on cycles 1-4, done on 5, ready on 6.
`ifdef PATTERN_TX_PARITY_EN
        launch(4'b1101, 4'd1, 3'd0, 7);
        check("t1_dout",  log_dout,  64'b1101100);
        check("t1_valid", log_valid, 64'b1111100);
        check("t1_done",  log_done,  64'b0000010);
        check("t1_ready", log_ready, 64'b0000001);
`else
        launch(4'b1101, 4'd1, 3'd0, 6);
        check("t1_dout",  log_dout,  64'b110100);
        check("t1_valid", log_valid, 64'b111100);
        check("t1_done",  log_done,  64'b000010);
        check("t1_ready", log_ready, 64'b000001);
`endif
        drain();

`ifndef PATTERN_TX_PARITY_EN
        // Three back-to-back repetitions without a bubble.
        launch(4'b1101, 4'd3, 3'd0, 13);
        check("t2_dout",  log_dout,  64'b1101110111010);
        check("t2_valid", log_valid, 64'b1111111111110);
        check("t2_done",  log_done,  64'b0000000000001);
        check("t2_detect", 64'(count_1101(log_dout >> 1, 12)), 64'd3);
        drain();

        // Two repetitions separated by a 2-cycle gap.
        launch(4'b1011, 4'd2, 3'd2, 11);
        check("t3_dout",  log_dout,  64'b10110010110);
        check("t3_valid", log_valid, 64'b11110011110);
        check("t3_done",  log_done,  64'b00000000001);
        drain();

        // reps=0 behaves as one repetition.
        launch(4'b0110, 4'd0, 3'd5, 5);
        check("t4_dout",  log_dout,  64'b01100);
        check("t4_valid", log_valid, 64'b11110);
        check("t4_done",  log_done,  64'b00001);
        drain();

        // start and inputs changed during SHIFT/GAP/DONE must not disturb the frame.
        launch(4'b1101, 4'd2, 3'd1, 1);
        for (int i = 1; i < 10; i++) begin
            start   = 1'($urandom);
            pattern = 4'b0010;
            reps    = 4'd5;
            gap     = 3'd3;
            step();
        end
        check("t5_dout", log_dout & 64'h3FF, 64'b1101011010);
        check("t5_done", log_done & 64'h3FF, 64'b0000000001);
        drain();
`endif

        // Asynchronous reset during the 2nd bit abandons the frame.
        launch(4'b1101, 4'd3, 3'd0, 2);
        async_reset();
        for (int i = 0; i < 4; i++) step();
        check("t6_no_done", log_done & 64'hF, 64'h0);
        launch(4'b0110, 4'd0, 3'd0, 2);
        drain();

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom % 4) == 0;
            pattern = 4'($urandom);
            reps    = (($urandom % 8) == 0) ? 4'($urandom) : 4'($urandom % 4);
            gap     = 3'($urandom);
            if (($urandom % 150) == 0) begin
                async_reset();
            end else begin
                step();
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
